// File: rtl/alu_pkg.sv
// Shared definitions for the ID/EX stage and its ALU control decoder.
// Contents:
//   - alu_sel_t         : operation select understood by the 32-bit ALU
//   - ALUOP_*           : two-bit ALUOp codes produced by the main decoder
//   - FUNCT_*           : R-type funct values the decoder recognises
//   - CTRL_*            : bit positions inside the 5-bit pass-through control word
//                         {reg_write, mem_read, mem_write, mem_to_reg, branch}
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10
    } alu_sel_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    localparam int CTRL_W          = 5;
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_BRANCH     = 0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: turns the main decoder's ALUOp and the R-type funct field
// into the ALU operation select, the B-invert bit (subtract) and an illegal flag.
// Ports:
//   alu_op  in  2  ALUOp from the main decoder
//   funct   in  6  R-type funct field
//   op      out 2  ALU operation select (AND/OR/ADD)
//   binvert out 1  invert B input (subtract)
//   illegal out 1  funct or ALUOp not supported
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [1:0] op,
    output logic       binvert,
    output logic       illegal
);

    // Anything unrecognised falls back to ADD so the datapath stays defined;
    // the illegal flag tells the rest of the pipeline not to trust the result.
    always_comb begin
        op      = ALU_ADD;
        binvert = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: ;
            ALUOP_SUB: binvert = 1'b1;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: ;
                    FUNCT_SUB: binvert = 1'b1;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage feeding the 32-bit ALU. Holds one decoded instruction,
// forwards operands from EX/MEM and MEM/WB, stalls on load-use hazards and
// inserts bubbles, and presents registered ALU controls.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_valid / id_ready             handshake with decode
//   id_rs1_val, id_rs2_val          register file read data
//   id_rs1, id_rs2, id_rd           register indices
//   id_imm, id_alu_src              immediate and in2 select
//   id_alu_op, id_funct, id_ctrl    decode controls
//   flush                           kill the held instruction
//   ex_ready                        downstream accepts the held instruction
//   exm_*, mwb_*                    forwarding sources
//   ex_valid                        held instruction valid
//   alu_in1, alu_in2, alu_op,
//   alu_binvert, alu_cin            ALU drive
//   ex_rd, ex_ctrl, ex_rs2_fwd,
//   ex_illegal                      pass-through to EX/MEM
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_rs1_val,
    input  logic [XLEN-1:0]   id_rs2_val,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alu_src,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_ctrl,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_reg_write,
    input  logic [XLEN-1:0]   mwb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_in1,
    output logic [XLEN-1:0]   alu_in2,
    output logic [1:0]        alu_op,
    output logic              alu_binvert,
    output logic              alu_cin,
    output logic [REG_AW-1:0] ex_rd,
    output logic [4:0]        ex_ctrl,
    output logic [XLEN-1:0]   ex_rs2_fwd,
    output logic              ex_illegal
);

    logic              valid_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0]   rs1_val_q, rs2_val_q, imm_q;
    logic              alu_src_q;
    logic [4:0]        ctrl_q;
    logic [1:0]        op_q;
    logic              binvert_q;
    logic              illegal_q;

    logic [1:0]        dec_op;
    logic              dec_binvert;
    logic              dec_illegal;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
    logic              hazard;
    logic              slot_free;

    // Youngest producer wins; register 0 is hard-wired zero and never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [XLEN-1:0]   held,
        input logic              e_we,
        input logic [REG_AW-1:0] e_rd,
        input logic [XLEN-1:0]   e_res,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic [XLEN-1:0]   m_res
    );
        if (src != '0 && e_we && e_rd == src)
            return e_res;
        else if (src != '0 && m_we && m_rd == src)
            return m_res;
        else
            return held;
    endfunction

    alu_ctrl_dec u_dec (
        .alu_op  (id_alu_op),
        .funct   (id_funct),
        .op      (dec_op),
        .binvert (dec_binvert),
        .illegal (dec_illegal)
    );

    assign fwd_rs1 = fwd_sel(rs1_q, rs1_val_q, exm_reg_write, exm_rd, exm_result,
                             mwb_reg_write, mwb_rd, mwb_result);
    assign fwd_rs2 = fwd_sel(rs2_q, rs2_val_q, exm_reg_write, exm_rd, exm_result,
                             mwb_reg_write, mwb_rd, mwb_result);

    // A held load cannot supply its data to the instruction right behind it;
    // rs2 only matters when it actually feeds the ALU (no immediate).
    assign hazard = valid_q && ctrl_q[CTRL_MEM_READ] && (rd_q != '0) &&
                    ((rd_q == id_rs1) || ((rd_q == id_rs2) && !id_alu_src));

    assign slot_free = !valid_q || ex_ready;
    assign id_ready  = slot_free && !hazard && !flush;

    // Priority: reset, flush, stall (refresh operands from forwarding so a
    // producer that retires during the stall is not lost), capture, bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            alu_src_q <= 1'b0;
            ctrl_q    <= '0;
            op_q      <= 2'b00;
            binvert_q <= 1'b0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (!slot_free) begin
            rs1_val_q <= fwd_rs1;
            rs2_val_q <= fwd_rs2;
        end else if (id_valid && !hazard) begin
            valid_q   <= 1'b1;
            rs1_q     <= id_rs1;
            rs2_q     <= id_rs2;
            rd_q      <= id_rd;
            rs1_val_q <= id_rs1_val;
            rs2_val_q <= id_rs2_val;
            imm_q     <= id_imm;
            alu_src_q <= id_alu_src;
            ctrl_q    <= id_ctrl;
            op_q      <= dec_op;
            binvert_q <= dec_binvert;
            illegal_q <= dec_illegal;
        end else begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end

    assign ex_valid    = valid_q;
    assign alu_in1     = fwd_rs1;
    assign alu_in2     = alu_src_q ? imm_q : fwd_rs2;
    assign alu_op      = op_q;
    assign alu_binvert = binvert_q;
    assign alu_cin     = binvert_q;
    assign ex_rd       = rd_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_rs2_fwd  = fwd_rs2;
    assign ex_illegal  = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations,
// followed by randomized traffic checked every cycle against a behavioural
// model of the stage's architectural behaviour.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_alu_src;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [4:0]  id_ctrl;
    logic        flush, ex_ready;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid;
    logic [31:0] alu_in1, alu_in2, ex_rs2_fwd;
    logic [1:0]  alu_op;
    logic        alu_binvert, alu_cin, ex_illegal;
    logic [4:0]  ex_rd, ex_ctrl;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_ctrl(id_ctrl),
        .flush(flush), .ex_ready(ex_ready),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_op(alu_op), .alu_binvert(alu_binvert), .alu_cin(alu_cin),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_rs2_fwd(ex_rs2_fwd),
        .ex_illegal(ex_illegal)
    );

    int nChecks = 0;
    int nFails  = 0;
    bit started = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of the instruction sitting in the stage, in architectural terms.
    typedef struct {
        bit        valid;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] v1, v2, imm;
        bit        src;
        bit [4:0]  ctrl;
        bit [1:0]  aluop;
        bit [5:0]  funct;
    } held_t;

    held_t m;

    function automatic bit [31:0] fwdModel(input bit [4:0] idx, input bit [31:0] held);
        if (idx != 0 && exm_reg_write && exm_rd == idx) return exm_result;
        if (idx != 0 && mwb_reg_write && mwb_rd == idx) return mwb_result;
        return held;
    endfunction

    // Returns {alu select, binvert, illegal}; ALU select codes: AND=0, OR=1, ADD=2.
    function automatic bit [3:0] decodeModel(input bit [1:0] aop, input bit [5:0] fn);
        if (aop == 2'd0) return {2'd2, 1'b0, 1'b0};
        if (aop == 2'd1) return {2'd2, 1'b1, 1'b0};
        if (aop == 2'd3) return {2'd2, 1'b0, 1'b1};
        if (fn == 6'h20) return {2'd2, 1'b0, 1'b0};
        if (fn == 6'h22) return {2'd2, 1'b1, 1'b0};
        if (fn == 6'h24) return {2'd0, 1'b0, 1'b0};
        if (fn == 6'h25) return {2'd1, 1'b0, 1'b0};
        return {2'd2, 1'b0, 1'b1};
    endfunction

    function automatic bit modelHazard();
        return m.valid && m.ctrl[3] && m.rd != 0 &&
               (m.rd == id_rs1 || (m.rd == id_rs2 && !id_alu_src));
    endfunction

    always @(posedge clk) begin
        bit [31:0] f1, f2;
        bit        free;
        f1   = fwdModel(m.rs1, m.v1);
        f2   = fwdModel(m.rs2, m.v2);
        free = !m.valid || ex_ready;
        if (rst) begin
            m = '{default: '0};
            started = 1'b1;
        end else if (flush) begin
            m.valid = 1'b0;
            m.ctrl  = '0;
        end else if (!free) begin
            m.v1 = f1;
            m.v2 = f2;
        end else if (id_valid && !modelHazard()) begin
            m = '{valid: 1'b1, rs1: id_rs1, rs2: id_rs2, rd: id_rd, v1: id_rs1_val,
                  v2: id_rs2_val, imm: id_imm, src: id_alu_src, ctrl: id_ctrl,
                  aluop: id_alu_op, funct: id_funct};
        end else begin
            m.valid = 1'b0;
            m.ctrl  = '0;
        end
    end

    always @(negedge clk) begin
        bit [31:0] f2;
        bit [3:0]  d;
        if (started) begin
            checkOutput("id_ready", {31'b0, id_ready},
                        {31'b0, (!m.valid || ex_ready) && !modelHazard() && !flush});
            checkOutput("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
            if (m.valid) begin
                f2 = fwdModel(m.rs2, m.v2);
                d  = decodeModel(m.aluop, m.funct);
                checkOutput("alu_in1", alu_in1, fwdModel(m.rs1, m.v1));
                checkOutput("alu_in2", alu_in2, m.src ? m.imm : f2);
                checkOutput("ex_rs2_fwd", ex_rs2_fwd, f2);
                checkOutput("alu_op", {30'b0, alu_op}, {30'b0, d[3:2]});
                checkOutput("alu_binvert", {31'b0, alu_binvert}, {31'b0, d[1]});
                checkOutput("alu_cin", {31'b0, alu_cin}, {31'b0, d[1]});
                checkOutput("ex_illegal", {31'b0, ex_illegal}, {31'b0, d[0]});
                checkOutput("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
                checkOutput("ex_ctrl", {27'b0, ex_ctrl}, {27'b0, m.ctrl});
            end else begin
                checkOutput("ex_ctrl_bubble", {27'b0, ex_ctrl}, 32'd0);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        id_valid = 0; id_rs1_val = 0; id_rs2_val = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_imm = 0; id_alu_src = 0; id_alu_op = 0; id_funct = 0; id_ctrl = 0;
        flush = 0; ex_ready = 1;
        exm_rd = 0; exm_reg_write = 0; exm_result = 0;
        mwb_rd = 0; mwb_reg_write = 0; mwb_result = 0;
    endtask

    task automatic applyStimulus(input bit v, input bit [4:0] r1, input bit [4:0] r2,
                                 input bit [4:0] rd, input bit [31:0] v1, input bit [31:0] v2,
                                 input bit [31:0] imm, input bit src, input bit [1:0] aop,
                                 input bit [5:0] fn, input bit [4:0] ctrl);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_val = v1; id_rs2_val = v2; id_imm = imm; id_alu_src = src;
        id_alu_op = aop; id_funct = fn; id_ctrl = ctrl;
    endtask

    initial begin
        logic [31:0] aluOut;
        setIdle();
        rst = 1;

        nextCycle();
        nextCycle();
        checkOutput("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("reset_alu_in1", alu_in1, 32'd0);
        checkOutput("reset_alu_in2", alu_in2, 32'd0);
        rst = 0;
        #1;
        checkOutput("reset_id_ready", {31'b0, id_ready}, 32'd1);

        // R-type subtract 10 - 3
        applyStimulus(1, 1, 2, 3, 10, 3, 0, 0, 2'b10, 6'b100010, 5'b10000);
        nextCycle();
        id_valid = 0;
        #1;
        aluOut = alu_in1 + (alu_binvert ? ~alu_in2 : alu_in2) + {31'b0, alu_cin};
        checkOutput("sub_alu_op", {30'b0, alu_op}, 32'd2);
        checkOutput("sub_binvert", {31'b0, alu_binvert}, 32'd1);
        checkOutput("sub_cin", {31'b0, alu_cin}, 32'd1);
        checkOutput("sub_in1", alu_in1, 32'd10);
        checkOutput("sub_in2", alu_in2, 32'd3);
        checkOutput("sub_result", aluOut, 32'd7);

        // Forwarding priority on a held rs1 (index 5, value 1)
        nextCycle();
        applyStimulus(1, 5, 6, 7, 1, 2, 0, 0, 2'b00, 6'h0, 5'b10000);
        nextCycle();
        id_valid = 0;
        exm_rd = 5; exm_reg_write = 1; exm_result = 32'hAA;
        mwb_rd = 5; mwb_reg_write = 1; mwb_result = 32'hBB;
        #1;
        checkOutput("fwd_exm_wins", alu_in1, 32'hAA);
        exm_rd = 0; mwb_rd = 0;
        #1;
        checkOutput("fwd_rd0_held", alu_in1, 32'd1);
        exm_reg_write = 0; mwb_rd = 5;
        #1;
        checkOutput("fwd_mwb", alu_in1, 32'hBB);
        mwb_reg_write = 0;

        // Load-use: lw rd=4 then an instruction reading rs1=4
        nextCycle();
        applyStimulus(1, 1, 0, 4, 100, 0, 8, 1, 2'b00, 6'h0, 5'b11010);
        nextCycle();
        applyStimulus(1, 4, 2, 6, 50, 7, 0, 0, 2'b00, 6'h0, 5'b10000);
        #1;
        checkOutput("loaduse_stall_ready", {31'b0, id_ready}, 32'd0);
        nextCycle();
        checkOutput("loaduse_bubble", {31'b0, ex_valid}, 32'd0);
        checkOutput("loaduse_ready_after", {31'b0, id_ready}, 32'd1);
        nextCycle();
        id_valid = 0;
        checkOutput("loaduse_captured", {31'b0, ex_valid}, 32'd1);
        checkOutput("loaduse_rd", {27'b0, ex_rd}, 32'd6);
        checkOutput("loaduse_in1", alu_in1, 32'd50);

        // Stall for three cycles, then flush while stalled
        applyStimulus(1, 8, 9, 7, 32'h11, 32'h22, 0, 0, 2'b00, 6'h0, 5'b10000);
        nextCycle();
        applyStimulus(1, 3, 3, 3, 1, 1, 0, 0, 2'b00, 6'h0, 5'b10000);
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_ready", {31'b0, id_ready}, 32'd0);
            checkOutput("stall_valid", {31'b0, ex_valid}, 32'd1);
            checkOutput("stall_in1", alu_in1, 32'h11);
            checkOutput("stall_in2", alu_in2, 32'h22);
            checkOutput("stall_rd", {27'b0, ex_rd}, 32'd7);
            nextCycle();
        end
        flush = 1;
        #1;
        checkOutput("flush_ready", {31'b0, id_ready}, 32'd0);
        nextCycle();
        flush = 0; ex_ready = 1; id_valid = 0;
        #1;
        checkOutput("flush_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("flush_ctrl", {27'b0, ex_ctrl}, 32'd0);

        // Unsupported funct and reserved ALUOp
        applyStimulus(1, 1, 2, 3, 5, 6, 0, 0, 2'b10, 6'b101010, 5'b10000);
        nextCycle();
        id_alu_op = 2'b11; id_funct = 6'b100100;
        #1;
        checkOutput("illegal_flag", {31'b0, ex_illegal}, 32'd1);
        checkOutput("illegal_alu_op", {30'b0, alu_op}, 32'd2);
        checkOutput("illegal_binvert", {31'b0, alu_binvert}, 32'd0);
        nextCycle();
        id_valid = 0;
        checkOutput("rsvd_illegal", {31'b0, ex_illegal}, 32'd1);
        checkOutput("rsvd_alu_op", {30'b0, alu_op}, 32'd2);

        // Randomized traffic checked by the per-cycle model
        for (int c = 0; c < 3000; c++) begin
            nextCycle();
            rst           = ($urandom_range(0, 99) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            ex_ready      = ($urandom_range(0, 3) != 0);
            id_valid      = ($urandom_range(0, 9) < 7);
            id_rs1        = 5'($urandom_range(0, 7));
            id_rs2        = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 7));
            id_rs1_val    = $urandom;
            id_rs2_val    = $urandom;
            id_imm        = $urandom;
            id_alu_src    = 1'($urandom_range(0, 1));
            id_alu_op     = 2'($urandom_range(0, 3));
            id_funct      = ($urandom_range(0, 1) == 1) ? 6'($urandom)
                                                        : {4'b1001, 2'($urandom_range(0, 3)) & 2'b11} & 6'b100111;
            id_ctrl       = 5'($urandom);
            exm_rd        = 5'($urandom_range(0, 7));
            exm_reg_write = 1'($urandom_range(0, 1));
            exm_result    = $urandom;
            mwb_rd        = 5'($urandom_range(0, 7));
            mwb_reg_write = 1'($urandom_range(0, 1));
            mwb_result    = $urandom;
        end
        nextCycle();
        setIdle();
        rst = 0;
        nextCycle();
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
